// File: rtl/mips_pkg.sv
// Shared MIPS constants and the writeback-source enumeration for the W stage.
package mips_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;

    localparam logic [5:0] F_JALR = 6'b001001;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;

    localparam logic [4:0] LINK_REG = 5'd31;

    typedef enum logic [1:0] {
        WD_ALU,
        WD_DM,
        WD_EXT,
        WD_PC8
    } wd_sel_t;

endpackage

// File: rtl/w_wb_decode.sv
// W-stage writeback decode: destination register, data source and write flag.
module w_wb_decode
    import mips_pkg::*;
(
    input  logic [31:0] Instr,
    input  logic        Check,
    output logic [4:0]  A3,
    output wd_sel_t     WDSel,
    output logic        Write
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unused_fields;

    assign op    = Instr[31:26];
    assign funct = Instr[5:0];
    assign rt    = Instr[20:16];
    assign rd    = Instr[15:11];
    assign unused_fields = ^{Instr[25:21], Instr[10:6]};

    always_comb begin
        A3    = '0;
        WDSel = WD_ALU;
        Write = 1'b0;
        case (op)
            OP_SPECIAL: begin
                case (funct)
                    F_ADDU, F_SUBU, F_AND, F_OR, F_SLT: begin
                        A3    = rd;
                        Write = 1'b1;
                    end
                    F_JALR: begin
                        A3    = rd;
                        WDSel = WD_PC8;
                        Write = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_ORI, OP_ADDIU: begin
                A3    = rt;
                Write = 1'b1;
            end
            OP_LUI: begin
                A3    = rt;
                WDSel = WD_EXT;
                Write = 1'b1;
            end
            OP_LW: begin
                A3    = rt;
                WDSel = WD_DM;
                Write = 1'b1;
            end
            OP_JAL: begin
                A3    = LINK_REG;
                WDSel = WD_PC8;
                Write = 1'b1;
            end
            default: ;
        endcase
        // A held conditional-link overrides whatever the opcode decoded to.
        if (Check) begin
            A3    = LINK_REG;
            WDSel = WD_PC8;
            Write = 1'b1;
        end
    end

endmodule

// File: rtl/w_grf.sv
// W-stage register file with same-cycle bypass and retired-instruction counter.
// Define W_GRF_TRACE_EN to print a trace line for every effective write.
module w_grf
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] W_Instr,
    input  logic [31:0] W_PC,
    input  logic [31:0] W_ALU,
    input  logic [31:0] W_DM,
    input  logic [31:0] W_EXT,
    input  logic        W_Check,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    output logic        W_WE,
    output logic [4:0]  W_A3,
    output logic [31:0] W_WD,
    output logic [31:0] RetireCnt
);

    logic [31:0] regs [32];
    wd_sel_t     wd_sel;
    logic        dec_write;
    logic [31:0] pc8;

    w_wb_decode u_decode (
        .Instr (W_Instr),
        .Check (W_Check),
        .A3    (W_A3),
        .WDSel (wd_sel),
        .Write (dec_write)
    );

    assign pc8  = W_PC + 32'd8;
    assign W_WE = dec_write && (W_A3 != '0);

    always_comb begin
        case (wd_sel)
            WD_ALU:  W_WD = W_ALU;
            WD_DM:   W_WD = W_DM;
            WD_EXT:  W_WD = W_EXT;
            WD_PC8:  W_WD = pc8;
            default: W_WD = W_ALU;
        endcase
    end

    always_comb begin
        if (A1 == '0)                     RD1 = '0;
        else if (W_WE && (A1 == W_A3))    RD1 = W_WD;
        else                              RD1 = regs[A1];
        if (A2 == '0)                     RD2 = '0;
        else if (W_WE && (A2 == W_A3))    RD2 = W_WD;
        else                              RD2 = regs[A2];
    end

    // W_WE is never set for A3 == 0, so register 0 stays zero after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            RetireCnt <= '0;
        end else begin
            if (W_WE) begin
                regs[W_A3] <= W_WD;
            end
            if (W_Instr != '0) begin
                RetireCnt <= RetireCnt + 32'd1;
            end
        end
    end

`ifdef W_GRF_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && W_WE) begin
            $display("@%08h: $%0d <= %08h", W_PC, W_A3, W_WD);
        end
    end
`endif

endmodule

// File: doc/w_grf.md
W_GRF -- requirements
Module: w_grf

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-003 SHALL have ports W_Instr, W_PC, W_ALU, W_DM, W_EXT  in  32 each  W-stage instruction word, PC, ALU result, data-memory word and extended immediate.
REQ-004 SHALL have port W_Check  in  1  link-override flag; 1 = conditional-link condition held.
REQ-005 SHALL have ports A1, A2  in  5 each  read addresses.
REQ-006 SHALL have ports RD1, RD2  out  32 each  read data.
REQ-007 SHALL have ports W_WE (out, 1), W_A3 (out, 5), W_WD (out, 32)  effective write enable, destination and data, exported to the hazard/forwarding unit.
REQ-008 SHALL have port RetireCnt  out  32  count of retired non-NOP instructions.

Function
REQ-009 Decode (combinational, W_Check=0) SHALL be:
- op 000000, funct in {addu 100001, subu 100011, and 100100, or 100101, slt 101010}: A3=rd, WD=W_ALU.
- op 000000, funct jalr 001001: A3=rd, WD=W_PC+8.
- op ori 001101 or addiu 001001: A3=rt, WD=W_ALU.
- op lui 001111: A3=rt, WD=W_EXT.
- op lw 100011: A3=rt, WD=W_DM.
- op jal 000011: A3=31, WD=W_PC+8.
- all other encodings, including jr, sw, beq and 0x00000000: no write.
REQ-010 When W_Check=1, A3 SHALL be 31 and WD SHALL be W_PC+8, regardless of the decode result.
REQ-011 W_WE SHALL be 1 only if a write is decoded (or forced by W_Check) and A3 != 0; W_A3/W_WD SHALL show decoded values even when W_WE=0.
REQ-012 On each rising edge with reset=0 and W_WE=1, register[W_A3] SHALL take W_WD; register 0 SHALL never change.
REQ-013 RD1 SHALL be 0 if A1=0; W_WD if W_WE=1 and A1=W_A3 (same-cycle bypass); else register[A1]. RD2 SHALL be the same with A2.
REQ-014 RetireCnt SHALL increment by 1 on every edge with reset=0 and W_Instr != 0, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-015 PC+8 SHALL be computed modulo 2^32.

Reset
REQ-016 On a reset edge, all 32 registers and RetireCnt SHALL become 0, and any write pending in that cycle SHALL be discarded.
REQ-017 During reset, RD1/RD2 SHALL follow REQ-013 combinationally; the first post-reset edge SHALL behave normally.

Configuration
REQ-018 With macro W_GRF_TRACE_EN defined, each effective write SHALL print "@<PC 8-hex>: $<A3 decimal> <= <WD 8-hex>" at that edge, using W_PC; without the macro, no print logic SHALL be compiled and behaviour SHALL be otherwise identical.

Structure
REQ-019 Opcode/funct constants and the writeback-source enumeration (ALU, DM, EXT, PC8) SHALL live in the shared package mips_pkg.
REQ-020 Decode SHALL be a combinational sub-module w_wb_decode (Instr, Check -> A3, WD source select, write flag); w_grf SHALL hold the register array, bypass logic and counter.

Verification
REQ-021 Reset, then addu rd=8 with W_ALU=0x12345678 -> W_WE=1, W_A3=8; with A1=8 in the same cycle RD1=0x12345678 (bypass); on the next cycle RD1=0x12345678 from the array.
REQ-022 lui rt=0 with W_EXT=0xABCD0000 -> W_WE=0, and RD1 with A1=0 stays 0.
REQ-023 jal with W_PC=0x00003000 -> $31=0x00003008; sw with W_Check=1 and W_PC=0x00003010 -> $31=0x00003018.
REQ-024 lw rt=5 with W_DM=0xDEADBEEF and W_ALU=0x1 -> $5=0xDEADBEEF; jr -> no register changes.
REQ-025 Write $9, then assert reset for 1 cycle together with an ori to $9 -> $9=0 and RetireCnt=0; then feed 3 non-NOP instructions and 2 zero words -> RetireCnt=3.
REQ-026 Preload RetireCnt to 0xFFFFFFFF by force, then feed one non-NOP instruction -> RetireCnt=0; with W_GRF_TRACE_EN, REQ-021 prints "@<PC>: $8 <= 12345678".
